// File: rtl/sauria_pkg.sv
// Shared SAURIA constants: configuration register layout, register map
// addresses and the config-controller state encoding.
package sauria_pkg;

    localparam int TOTAL_REGS_CON = 8;
    localparam int TOTAL_REGS_ACT = 8;
    localparam int TOTAL_REGS_WEI = 8;
    localparam int TOTAL_REGS_OUT = 8;

    localparam int CFG_REG_W  = 32;
    localparam int CFG_N_REGS = TOTAL_REGS_CON + TOTAL_REGS_ACT + TOTAL_REGS_WEI + TOTAL_REGS_OUT;

    // Word offsets of each group inside the packed active configuration
    localparam int CFG_BASE_CON = 0;
    localparam int CFG_BASE_ACT = CFG_BASE_CON + TOTAL_REGS_CON;
    localparam int CFG_BASE_WEI = CFG_BASE_ACT + TOTAL_REGS_ACT;
    localparam int CFG_BASE_OUT = CFG_BASE_WEI + TOTAL_REGS_WEI;

    localparam int CFG_ADDR_CTRL   = 0;
    localparam int CFG_ADDR_STATUS = 1;
    localparam int CFG_ADDR_SHADOW = 2;

    typedef enum logic [1:0] {
        CFG_IDLE,
        CFG_COMMIT,
        CFG_RUN
    } cfg_state_t;

endpackage

// File: rtl/sauria_cfg_shadow_regs.sv
// Double-buffered SAURIA configuration registers: host fills shadow words while
// the core runs, a START commits shadow->active and pulses the core start.
module sauria_cfg_shadow_regs
    import sauria_pkg::*;
#(
    parameter int REG_W  = CFG_REG_W,
    parameter int N_REGS = CFG_N_REGS,
    parameter int ADDR_W = $clog2(N_REGS + 2)
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_cfg_req,
    input  logic                    i_cfg_we,
    input  logic [ADDR_W-1:0]       i_cfg_addr,
    input  logic [REG_W-1:0]        i_cfg_wdata,
    output logic                    o_cfg_rvalid,
    output logic [REG_W-1:0]        o_cfg_rdata,
    output logic [N_REGS*REG_W-1:0] o_cfg_active,
    output logic                    o_start,
    input  logic                    i_done,
    output logic                    o_irq
);

    logic [REG_W-1:0]  shadow [N_REGS];
    logic [REG_W-1:0]  active [N_REGS];
    logic [N_REGS-1:0] shadow_sel;
    logic [N_REGS-1:0] shadow_we;

    cfg_state_t state, state_d;
    logic       pending, pending_d;
    logic       irq_en, done_sticky, err_sticky;
    logic       done_set, err_set;

    logic       wr, rd, ctrl_sel, status_sel, unmapped, start_req;
    logic       done_w1c, err_w1c, busy;
    logic [REG_W-1:0] rd_mux;

    assign wr         = i_cfg_req & i_cfg_we;
    assign rd         = i_cfg_req & ~i_cfg_we;
    assign ctrl_sel   = (i_cfg_addr == ADDR_W'(CFG_ADDR_CTRL));
    assign status_sel = (i_cfg_addr == ADDR_W'(CFG_ADDR_STATUS));
    assign unmapped   = ~(ctrl_sel | status_sel | (|shadow_sel));
    assign start_req  = wr & ctrl_sel & i_cfg_wdata[0];
    assign done_w1c   = wr & status_sel & i_cfg_wdata[2];
    assign err_w1c    = wr & status_sel & i_cfg_wdata[3];
    assign busy       = (state != CFG_IDLE);
    assign o_irq      = done_sticky & irq_en;

    always_comb begin
        for (int k = 0; k < N_REGS; k++) begin
            shadow_sel[k] = (i_cfg_addr == ADDR_W'(k + CFG_ADDR_SHADOW));
        end
        shadow_we = shadow_sel & {N_REGS{wr}};
    end

    for (genvar k = 0; k < N_REGS; k++) begin : g_reg
        // NOTE: the register file is reset word by word so the core never sees stale
        // configuration after a mid-job reset; it is flops, not a RAM macro.
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end else begin
                if (shadow_we[k]) shadow[k] <= i_cfg_wdata;
                // Copy uses the pre-write shadow value when a write lands in the same cycle
                if (state == CFG_COMMIT) active[k] <= shadow[k];
            end
        end
        assign o_cfg_active[k*REG_W +: REG_W] = active[k];
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d   = state;
        pending_d = pending;
        done_set  = 1'b0;
        err_set   = wr & unmapped;
        case (state)
            CFG_IDLE: begin
                if (i_done) err_set = 1'b1;
                if (start_req) state_d = CFG_COMMIT;
            end
            CFG_COMMIT: begin
                state_d = CFG_RUN;
                if (i_done) err_set = 1'b1;
                if (start_req) begin
                    if (pending) err_set = 1'b1;
                    else pending_d = 1'b1;
                end
            end
            CFG_RUN: begin
                if (i_done) begin
                    done_set = 1'b1;
                    if (pending) begin
                        pending_d = 1'b0;
                        state_d   = CFG_COMMIT;
                    end else begin
                        state_d = CFG_IDLE;
                    end
                end
                // A start arriving with done sees the post-done view of the queue
                if (start_req) begin
                    if (state_d == CFG_IDLE) state_d = CFG_COMMIT;
                    else if (pending_d) err_set = 1'b1;
                    else pending_d = 1'b1;
                end
            end
            default: state_d = CFG_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        if (ctrl_sel) rd_mux[1] = irq_en;
        if (status_sel) rd_mux[3:0] = {err_sticky, done_sticky, pending, busy};
        for (int k = 0; k < N_REGS; k++) begin
            if (shadow_sel[k]) rd_mux = shadow[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!i_rstn) begin
            state        <= CFG_IDLE;
            pending      <= 1'b0;
            irq_en       <= 1'b0;
            done_sticky  <= 1'b0;
            err_sticky   <= 1'b0;
            o_start      <= 1'b0;
            o_cfg_rvalid <= 1'b0;
            o_cfg_rdata  <= '0;
        end else begin
            state        <= state_d;
            pending      <= pending_d;
            o_start      <= (state == CFG_COMMIT);
            o_cfg_rvalid <= rd;
            if (rd) o_cfg_rdata <= rd_mux;
            if (wr && ctrl_sel) irq_en <= i_cfg_wdata[1];
            // Hardware set beats a simultaneous write-one-to-clear
            done_sticky  <= done_set | (done_sticky & ~done_w1c);
            err_sticky   <= err_set | (err_sticky & ~err_w1c);
        end
    end

endmodule

// File: tb/tb_sauria_cfg_shadow_regs.sv
// Self-checking bench for sauria_cfg_shadow_regs: register-map table, directed
// job-queue sequences, then random traffic against a job-count reference model.
module tb_sauria_cfg_shadow_regs;
    import sauria_pkg::*;

    localparam int REG_W  = CFG_REG_W;
    localparam int N_REGS = CFG_N_REGS;
    localparam int ADDR_W = $clog2(N_REGS + 2);

    logic                    clk, rst_n;
    logic                    cfg_req, cfg_we, done;
    logic [ADDR_W-1:0]       cfg_addr;
    logic [REG_W-1:0]        cfg_wdata;
    logic                    cfg_rvalid, start, irq;
    logic [REG_W-1:0]        cfg_rdata;
    logic [N_REGS*REG_W-1:0] cfg_active;

    int checks   = 0;
    int failures = 0;

    sauria_cfg_shadow_regs dut (
        .i_clk        (clk),
        .i_rstn       (rst_n),
        .i_cfg_req    (cfg_req),
        .i_cfg_we     (cfg_we),
        .i_cfg_addr   (cfg_addr),
        .i_cfg_wdata  (cfg_wdata),
        .o_cfg_rvalid (cfg_rvalid),
        .o_cfg_rdata  (cfg_rdata),
        .o_cfg_active (cfg_active),
        .o_start      (start),
        .i_done       (done),
        .o_irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [REG_W-1:0]  wdata;
        logic [REG_W-1:0]  exp_rdata;
    } bus_vec_t;

    bus_vec_t vecs[14];

    // Reference model: counts accepted-but-unfinished jobs instead of tracking states
    logic [REG_W-1:0]        m_shadow [N_REGS];
    logic [N_REGS*REG_W-1:0] m_active;
    logic [REG_W-1:0]        m_rdata;
    int m_jobs;
    bit m_launch, m_running, m_start, m_rvalid, m_irq_en, m_done, m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_active(input string name, input logic [N_REGS*REG_W-1:0] exp);
        int bad;
        bad = -1;
        checks++;
        if (cfg_active !== exp) begin
            failures++;
            for (int k = 0; k < N_REGS; k++)
                if (bad < 0 && cfg_active[k*REG_W +: REG_W] !== exp[k*REG_W +: REG_W]) bad = k;
            $display("FAIL %s: active word %0d got 0x%08h expected 0x%08h", name, bad,
                     cfg_active[bad*REG_W +: REG_W], exp[bad*REG_W +: REG_W]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [REG_W-1:0] d);
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_req = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [ADDR_W-1:0] a, input logic [REG_W-1:0] exp);
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = a;
        tick();
        cfg_req = 1'b0;
        check({name, "_rvalid"}, cfg_rvalid, 1);
        check(name, cfg_rdata, exp);
    endtask

    task automatic do_reset();
        cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; done = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_REGS; k++) m_shadow[k] = '0;
        m_active = '0; m_rdata = '0; m_jobs = 0;
        m_launch = 0; m_running = 0; m_start = 0; m_rvalid = 0;
        m_irq_en = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step(input bit req, input bit we, input int a, input logic [31:0] d, input bit dn);
        bit wr, rd, is_shadow, mapped, done_ok, accept_start, running_after;
        logic [31:0] rv;
        int jobs;
        wr = req && we;
        rd = req && !we;
        is_shadow = (a >= CFG_ADDR_SHADOW) && (a < N_REGS + CFG_ADDR_SHADOW);
        mapped = (a == CFG_ADDR_CTRL) || (a == CFG_ADDR_STATUS) || is_shadow;
        rv = 0;
        if (a == CFG_ADDR_CTRL) rv = {30'd0, m_irq_en, 1'b0};
        else if (a == CFG_ADDR_STATUS) rv = {28'd0, m_err, m_done, m_jobs == 2, m_jobs > 0};
        else if (is_shadow) rv = m_shadow[a - CFG_ADDR_SHADOW];
        m_rvalid = rd;
        if (rd) m_rdata = rv;
        // A launch copies the configuration and the core sees start one cycle later
        m_start = m_launch;
        if (m_launch)
            for (int k = 0; k < N_REGS; k++) m_active[k*REG_W +: REG_W] = m_shadow[k];
        done_ok = dn && m_running;
        jobs = m_jobs - (done_ok ? 1 : 0);
        accept_start = wr && (a == CFG_ADDR_CTRL) && d[0] && (jobs < 2);
        if (accept_start) jobs++;
        running_after = m_launch || (m_running && !done_ok);
        m_err = (wr && !mapped) || (dn && !done_ok) || (wr && a == CFG_ADDR_CTRL && d[0] && !accept_start)
                || (m_err && !(wr && a == CFG_ADDR_STATUS && d[3]));
        m_done = done_ok || (m_done && !(wr && a == CFG_ADDR_STATUS && d[2]));
        if (wr && a == CFG_ADDR_CTRL) m_irq_en = d[1];
        if (wr && is_shadow) m_shadow[a - CFG_ADDR_SHADOW] = d;
        m_jobs = jobs;
        m_running = running_after;
        m_launch = (jobs > 0) && !running_after;
    endtask

    initial begin
        int n_starts;
        int r, a;
        bit rq, w, dn;
        logic [31:0] d;

        vecs[0]  = '{1'b0, 6'd1,  32'h0,        32'h0};
        vecs[1]  = '{1'b0, 6'd5,  32'h0,        32'h0};
        vecs[2]  = '{1'b0, 6'd0,  32'h0,        32'h0};
        vecs[3]  = '{1'b0, 6'd63, 32'h0,        32'h0};
        vecs[4]  = '{1'b1, 6'd40, 32'h11111111, 32'h0};
        vecs[5]  = '{1'b0, 6'd1,  32'h0,        32'h8};
        vecs[6]  = '{1'b1, 6'd1,  32'h8,        32'h0};
        vecs[7]  = '{1'b0, 6'd1,  32'h0,        32'h0};
        vecs[8]  = '{1'b1, 6'd0,  32'h2,        32'h0};
        vecs[9]  = '{1'b0, 6'd0,  32'h0,        32'h2};
        vecs[10] = '{1'b1, 6'd0,  32'h0,        32'h0};
        vecs[11] = '{1'b1, 6'd7,  32'hCAFEF00D, 32'h0};
        vecs[12] = '{1'b0, 6'd7,  32'h0,        32'hCAFEF00D};
        vecs[13] = '{1'b0, 6'd33, 32'h0,        32'h0};

        do_reset();
        #1;
        check("rst_start", start, 0);
        check("rst_irq", irq, 0);
        check("rst_rvalid", cfg_rvalid, 0);
        check("rst_rdata", cfg_rdata, 0);
        check_active("rst_active", '0);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].addr, vecs[i].wdata);
                check($sformatf("vec%0d_wr_rvalid", i), cfg_rvalid, 0);
            end else begin
                bus_read($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rdata);
            end
        end
        tick();
        check("rvalid_one_cycle", cfg_rvalid, 0);

        // First job: commit, single start pulse, busy only
        bus_write(6'd2, 32'hDEADBEEF);
        bus_write(6'd0, 32'h1);
        check("commit_no_start_yet", start, 0);
        tick();
        check("first_start", start, 1);
        check("first_active0", cfg_active[31:0], 32'hDEADBEEF);
        check("first_active5", cfg_active[5*REG_W +: REG_W], 32'hCAFEF00D);
        tick();
        check("first_start_one_cycle", start, 0);
        bus_read("status_run", 6'd1, 32'h1);

        // Shadow write during RUN stays hidden; queued start launches on done
        bus_write(6'd2, 32'h12345678);
        check("active_stable_in_run", cfg_active[31:0], 32'hDEADBEEF);
        bus_write(6'd0, 32'h1);
        bus_read("status_pending", 6'd1, 32'h3);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("second_commit_no_start", start, 0);
        tick();
        check("second_start", start, 1);
        check("second_active0", cfg_active[31:0], 32'h12345678);
        bus_read("status_done", 6'd1, 32'h5);

        // Overflowing the one-deep queue flags an error, W1C clears it
        bus_write(6'd0, 32'h1);
        bus_write(6'd0, 32'h1);
        bus_read("status_err", 6'd1, 32'hF);
        bus_write(6'd1, 32'h8);
        bus_read("status_err_clr", 6'd1, 32'h7);

        // Interrupt level and set-beats-clear
        bus_write(6'd0, 32'h2);
        check("irq_on_sticky", irq, 1);
        bus_write(6'd1, 32'h4);
        check("irq_cleared", irq, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("irq_after_done", irq, 1);
        bus_write(6'd1, 32'h4);
        check("irq_cleared2", irq, 0);
        done = 1'b1;
        bus_write(6'd1, 32'h4);
        done = 1'b0;
        check("irq_set_wins", irq, 1);
        bus_read("status_idle_done", 6'd1, 32'h4);

        // Reset in RUN with a queued job
        bus_write(6'd0, 32'h3);
        bus_write(6'd0, 32'h3);
        bus_read("status_before_rst", 6'd1, 32'h7);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_start", start, 0);
        check("midrst_irq", irq, 0);
        check("midrst_rvalid", cfg_rvalid, 0);
        check("midrst_rdata", cfg_rdata, 0);
        check_active("midrst_active", '0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        n_starts = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (start) n_starts++;
        end
        check("no_start_after_rst", n_starts, 0);
        bus_read("status_after_rst", 6'd1, 32'h0);

        // Random traffic against the reference model
        do_reset();
        model_reset();
        #1;
        for (int i = 0; i < 3000 && failures < 20; i++) begin
            rq = ($urandom % 4) != 0;
            w  = $urandom % 2;
            r  = $urandom % 8;
            if (r < 2) a = CFG_ADDR_CTRL;
            else if (r == 2) a = CFG_ADDR_STATUS;
            else if (r == 3) a = $urandom % 64;
            else a = CFG_ADDR_SHADOW + ($urandom % N_REGS);
            d  = $urandom;
            dn = ($urandom % 6) == 0;
            cfg_req = rq; cfg_we = w; cfg_addr = ADDR_W'(a); cfg_wdata = d; done = dn;
            model_step(rq, w, a, d, dn);
            tick();
            check("rnd_start", start, m_start);
            check("rnd_irq", irq, m_irq_en & m_done);
            check("rnd_rvalid", cfg_rvalid, m_rvalid);
            check("rnd_rdata", cfg_rdata, m_rdata);
            check_active("rnd_active", m_active);
        end
        cfg_req = 1'b0; done = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
